// File: rtl/call_int_sequencer_pkg.sv
// Shared types and defaults for the CALL/RET/RTI/interrupt sequencer.
//   state_e : one value per sequencer cycle type
//   kind_e  : which sequence is in flight (selects branch and LOAD source)
package call_int_sequencer_pkg;

  localparam int unsigned FLAG_W = 3;
  localparam logic [31:0] INT_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StPushHi,
    StPushLo,
    StPushFlg,
    StPopFlg,
    StPopLo,
    StPopHi,
    StLoad
  } state_e;

  typedef enum logic [1:0] {
    KindCall,
    KindRet,
    KindRti,
    KindInt
  } kind_e;

endpackage

// File: rtl/call_int_sequencer_if.sv
// Data-memory port taken over by the sequencer while busy.
//   master : sequencer side (drives re/we/addr/wdata, receives rdata)
//   slave  : memory side
// mem_rdata is valid the cycle after a read.
interface call_int_sequencer_if #(
  parameter int unsigned ADDR_W = 11
) ();

  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;

  modport master (
    output mem_re,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_re,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/call_int_sequencer.sv
// Multi-cycle CALL / RET / RTI / interrupt-entry controller.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   call/ret/rti_req         single-cycle requests from EX (accepted in IDLE only)
//   int_req                  interrupt pulse, latched until accepted
//   pc_ret, pc_target        return PC / CALL target, captured on acceptance
//   flags_in                 flags, captured on acceptance
//   sp                       external stack pointer
//   mem                      data-memory port (master side)
//   busy                     stall for IF/ID/EX
//   sp_we, sp_next           SP write port
//   pc_load, pc_value, flush PC redirect at end of sequence
//   flags_restore, flags_out flag reload at end of RTI
//   int_ack                  pulse in the cycle an interrupt is accepted
module call_int_sequencer #(
  parameter int unsigned ADDR_W     = 11,
  parameter logic [31:0] INT_VECTOR = call_int_sequencer_pkg::INT_VECTOR_DEFAULT,
  parameter int unsigned FLAG_W     = call_int_sequencer_pkg::FLAG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                call_req,
  input  logic                ret_req,
  input  logic                rti_req,
  input  logic                int_req,
  input  logic [31:0]         pc_ret,
  input  logic [31:0]         pc_target,
  input  logic [FLAG_W-1:0]   flags_in,
  input  logic [ADDR_W-1:0]   sp,
  call_int_sequencer_if.master mem,
  output logic                busy,
  output logic                sp_we,
  output logic [ADDR_W-1:0]   sp_next,
  output logic                pc_load,
  output logic [31:0]         pc_value,
  output logic                flush,
  output logic                flags_restore,
  output logic [FLAG_W-1:0]   flags_out,
  output logic                int_ack
);
  import call_int_sequencer_pkg::*;

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic              int_pending_q, int_pending_d;
  logic [31:0]       pc_ret_q, pc_ret_d;
  logic [31:0]       pc_target_q, pc_target_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [15:0]       lo_q, lo_d;
  logic              accept, take_int, int_seen;
  logic [ADDR_W-1:0] sp_inc, sp_dec;

  assign sp_inc = sp + ADDR_W'(1);
  assign sp_dec = sp - ADDR_W'(1);
  // A pulse arriving in IDLE is taken in the same cycle.
  assign int_seen = int_pending_q | int_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      kind_q        <= KindCall;
      int_pending_q <= 1'b0;
      pc_ret_q      <= '0;
      pc_target_q   <= '0;
      flags_q       <= '0;
      lo_q          <= '0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      int_pending_q <= int_pending_d;
      pc_ret_q      <= pc_ret_d;
      pc_target_q   <= pc_target_d;
      flags_q       <= flags_d;
      lo_q          <= lo_d;
    end
  end

  // Next state, arbitration and capture.
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    int_pending_d = int_seen;
    pc_ret_d      = pc_ret_q;
    pc_target_d   = pc_target_q;
    flags_d       = flags_q;
    lo_d          = lo_q;
    accept        = 1'b0;
    take_int      = 1'b0;
    unique case (state_q)
      StIdle: begin
        accept = rti_req | ret_req | call_req | int_seen;
        if (rti_req) begin
          state_d = StPopFlg;
          kind_d  = KindRti;
        end else if (ret_req) begin
          state_d = StPopLo;
          kind_d  = KindRet;
        end else if (call_req) begin
          state_d = StPushHi;
          kind_d  = KindCall;
        end else if (int_seen) begin
          state_d       = StPushHi;
          kind_d        = KindInt;
          take_int      = 1'b1;
          int_pending_d = 1'b0;
        end
      end
      StPushHi:  state_d = StPushLo;
      StPushLo:  state_d = (kind_q == KindInt) ? StPushFlg : StLoad;
      StPushFlg: state_d = StLoad;
      StPopFlg:  state_d = StPopLo;
      StPopLo: begin
        state_d = StPopHi;
        // Data from the POP_FLG read lands here; only meaningful for RTI.
        if (kind_q == KindRti) flags_d = mem.mem_rdata[FLAG_W-1:0];
      end
      StPopHi: begin
        state_d = StLoad;
        lo_d    = mem.mem_rdata;
      end
      StLoad:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (accept) begin
      pc_ret_d    = pc_ret;
      pc_target_d = pc_target;
      flags_d     = flags_in;
    end
  end

  // Output decode from state and captured values.
  always_comb begin
    busy          = (state_q != StIdle);
    mem.mem_re    = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    sp_we         = 1'b0;
    sp_next       = '0;
    pc_load       = 1'b0;
    pc_value      = '0;
    flush         = 1'b0;
    flags_restore = 1'b0;
    flags_out     = '0;
    // Reset gating keeps int_ack low while rst is held with int_req high.
    int_ack       = take_int & ~rst;
    unique case (state_q)
      StPushHi, StPushLo, StPushFlg: begin
        mem.mem_we   = 1'b1;
        mem.mem_addr = sp;
        sp_we        = 1'b1;
        sp_next      = sp_dec;
        unique case (state_q)
          StPushHi: mem.mem_wdata = pc_ret_q[31:16];
          StPushLo: mem.mem_wdata = pc_ret_q[15:0];
          default:  mem.mem_wdata = 16'(flags_q);
        endcase
      end
      StPopFlg, StPopLo, StPopHi: begin
        mem.mem_re   = 1'b1;
        mem.mem_addr = sp_inc;
        sp_we        = 1'b1;
        sp_next      = sp_inc;
      end
      StLoad: begin
        pc_load = 1'b1;
        flush   = 1'b1;
        unique case (kind_q)
          KindCall: pc_value = pc_target_q;
          KindInt:  pc_value = INT_VECTOR;
          default:  pc_value = {mem.mem_rdata, lo_q};
        endcase
        if (kind_q == KindRti) begin
          flags_restore = 1'b1;
          flags_out     = flags_q;
        end
      end
      default: ;
    endcase
  end

endmodule
